// File: rtl/latency_stats_pkg.sv
// Shared constants for latency_stats: frame geometry, field byte offsets and
// readout FSM encoding.
package latency_stats_pkg;

  localparam int FRAME_LEN = 31;
  localparam int IDX_W     = 5;

  localparam int OFS_CNT  = 0;
  localparam int OFS_AMIN = 2;
  localparam int OFS_AMAX = 6;
  localparam int OFS_ASUM = 10;
  localparam int OFS_BMIN = 16;
  localparam int OFS_BMAX = 20;
  localparam int OFS_BSUM = 24;
  localparam int OFS_CHK  = 30;

  // Frame field widths in bits (wire format, independent of RTL parameters)
  localparam int FW_CNT = 16;
  localparam int FW_LAT = 32;
  localparam int FW_SUM = 48;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/latency_stats_channel.sv
// One latency channel: live min/max/sum plus a snapshot copy taken on snap.
module latency_stats_channel #(
  parameter int LAT_W = 32,
  parameter int SUM_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             clear,
  input  logic             snap,
  input  logic [LAT_W-1:0] x,
  output logic [LAT_W-1:0] snap_min,
  output logic [LAT_W-1:0] snap_max,
  output logic [SUM_W-1:0] snap_sum
);

  logic [LAT_W-1:0] min_q, min_d, max_q, max_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [LAT_W-1:0] smin_q, smin_d, smax_q, smax_d;
  logic [SUM_W-1:0] ssum_q, ssum_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    sum_d = sum_q;
    if (clear) begin
      min_d = '1;
      max_d = '0;
      sum_d = '0;
    end else if (sample_en) begin
      min_d = (x < min_q) ? x : min_q;
      max_d = (x > max_q) ? x : max_q;
      sum_d = sum_q + SUM_W'(x);
    end
  end

  // Snapshot captures the pre-update live values, so a coincident sample
  // lands only in the live registers.
  always_comb begin
    smin_d = snap ? min_q : smin_q;
    smax_d = snap ? max_q : smax_q;
    ssum_d = snap ? sum_q : ssum_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q  <= '1;
      max_q  <= '0;
      sum_q  <= '0;
      smin_q <= '1;
      smax_q <= '0;
      ssum_q <= '0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      sum_q  <= sum_d;
      smin_q <= smin_d;
      smax_q <= smax_d;
      ssum_q <= ssum_d;
    end
  end

  assign snap_min = smin_q;
  assign snap_max = smax_q;
  assign snap_sum = ssum_q;

endmodule

// File: rtl/latency_stats.sv
// Running latency statistics with a 31-byte little-endian snapshot frame
// streamed one byte per rd_next pulse.
module latency_stats
  import latency_stats_pkg::*;
#(
  parameter int LAT_W = 32,
  parameter int CNT_W = 16,
  parameter int SUM_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [LAT_W-1:0] int_ack_lat,
  input  logic [LAT_W-1:0] spi_lat,
  input  logic             clear,
  input  logic             rd_start,
  input  logic             rd_next,
  output logic [7:0]       rd_byte,
  output logic             rd_active,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             saturated
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d, snap_cnt_q, snap_cnt_d;
  logic             saturated_q, saturated_d;
  logic             sample_en, snap;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d, idx_inc;
  logic [7:0]       checksum_q, checksum_d, chk_upd;
  logic [7:0]       rd_byte_q, rd_byte_d, next_byte;
  logic             rd_active_q, rd_active_d;

  logic [LAT_W-1:0] a_snap_min, a_snap_max, b_snap_min, b_snap_max;
  logic [SUM_W-1:0] a_snap_sum, b_snap_sum;
  logic [8*(FRAME_LEN-1)-1:0] frame_vec;

  assign sample_en = sample_valid && !clear && (count_q != CNT_MAX);

  latency_stats_channel #(.LAT_W(LAT_W), .SUM_W(SUM_W)) u_chan_a (
    .clk      (clk),
    .rst      (rst),
    .sample_en(sample_en),
    .clear    (clear),
    .snap     (snap),
    .x        (int_ack_lat),
    .snap_min (a_snap_min),
    .snap_max (a_snap_max),
    .snap_sum (a_snap_sum)
  );

  latency_stats_channel #(.LAT_W(LAT_W), .SUM_W(SUM_W)) u_chan_b (
    .clk      (clk),
    .rst      (rst),
    .sample_en(sample_en),
    .clear    (clear),
    .snap     (snap),
    .x        (spi_lat),
    .snap_min (b_snap_min),
    .snap_max (b_snap_max),
    .snap_sum (b_snap_sum)
  );

  always_comb begin
    count_d     = count_q;
    saturated_d = saturated_q;
    if (clear) begin
      count_d     = '0;
      saturated_d = 1'b0;
    end else if (sample_en) begin
      count_d     = count_q + 1'b1;
      saturated_d = (count_q == CNT_MAX - 1'b1);
    end
  end

  // Fixed wire-format layout of bytes 0-29 built from the snapshot registers.
  always_comb begin
    frame_vec = '0;
    frame_vec[OFS_CNT*8  +: FW_CNT] = FW_CNT'(snap_cnt_q);
    frame_vec[OFS_AMIN*8 +: FW_LAT] = FW_LAT'(a_snap_min);
    frame_vec[OFS_AMAX*8 +: FW_LAT] = FW_LAT'(a_snap_max);
    frame_vec[OFS_ASUM*8 +: FW_SUM] = FW_SUM'(a_snap_sum);
    frame_vec[OFS_BMIN*8 +: FW_LAT] = FW_LAT'(b_snap_min);
    frame_vec[OFS_BMAX*8 +: FW_LAT] = FW_LAT'(b_snap_max);
    frame_vec[OFS_BSUM*8 +: FW_SUM] = FW_SUM'(b_snap_sum);
  end

  // Byte presented after an advance; the checksum byte is the updated XOR.
  assign idx_inc   = index_q + 1'b1;
  assign chk_upd   = checksum_q ^ rd_byte_q;
  assign next_byte = (idx_inc == IDX_W'(OFS_CHK)) ? chk_upd
                                                  : frame_vec[{idx_inc, 3'b000} +: 8];

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    checksum_d  = checksum_q;
    rd_byte_d   = rd_byte_q;
    rd_active_d = rd_active_q;
    snap        = 1'b0;
    snap_cnt_d  = snap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          snap        = 1'b1;
          snap_cnt_d  = count_q;
          index_d     = '0;
          checksum_d  = '0;
          state_d     = SEND;
          rd_active_d = 1'b1;
          // Snapshot is not loaded yet, so byte 0 comes from the live count.
          rd_byte_d   = 8'(count_q);
        end
      end
      SEND: begin
        if (rd_next) begin
          if (index_q == IDX_W'(OFS_CHK)) begin
            state_d     = IDLE;
            index_d     = '0;
            rd_active_d = 1'b0;
            rd_byte_d   = '0;
          end else begin
            index_d    = idx_inc;
            checksum_d = chk_upd;
            rd_byte_d  = next_byte;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      snap_cnt_q  <= '0;
      saturated_q <= 1'b0;
      state_q     <= IDLE;
      index_q     <= '0;
      checksum_q  <= '0;
      rd_byte_q   <= '0;
      rd_active_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      snap_cnt_q  <= snap_cnt_d;
      saturated_q <= saturated_d;
      state_q     <= state_d;
      index_q     <= index_d;
      checksum_q  <= checksum_d;
      rd_byte_q   <= rd_byte_d;
      rd_active_q <= rd_active_d;
    end
  end

  assign rd_byte    = rd_byte_q;
  assign rd_active  = rd_active_q;
  assign sample_cnt = count_q;
  assign saturated  = saturated_q;

endmodule

// File: tb/tb_latency_stats.sv
// Scoreboard bench for latency_stats: expected frame bytes are queued when a
// read starts and a monitor compares them as each byte is consumed.
module tb_latency_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [31:0] int_ack_lat;
  logic [31:0] spi_lat;
  logic        clear;
  logic        rd_start;
  logic        rd_next;
  logic [7:0]  rd_byte;
  logic        rd_active;
  logic [15:0] sample_cnt;
  logic        saturated;

  int n_pass  = 0;
  int n_total = 0;

  // Reference statistics model
  logic [15:0] m_cnt;
  logic [31:0] m_amin, m_amax, m_bmin, m_bmax;
  logic [47:0] m_asum, m_bsum;

  logic [7:0] exp_q[$];

  latency_stats dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .int_ack_lat (int_ack_lat),
    .spi_lat     (spi_lat),
    .clear       (clear),
    .rd_start    (rd_start),
    .rd_next     (rd_next),
    .rd_byte     (rd_byte),
    .rd_active   (rd_active),
    .sample_cnt  (sample_cnt),
    .saturated   (saturated)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: each consumed byte is compared against the head of the queue.
  always @(negedge clk) begin
    if (rd_active && rd_next) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {56'd0, rd_byte}, 64'hDEAD);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rd_byte", {56'd0, rd_byte}, {56'd0, e});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt  = '0;
    m_amin = '1; m_amax = '0; m_asum = '0;
    m_bmin = '1; m_bmax = '0; m_bsum = '0;
  endtask

  task automatic model_sample(input logic [31:0] a, input logic [31:0] b);
    if (m_cnt != 16'hFFFF) begin
      m_cnt++;
      if (a < m_amin) m_amin = a;
      if (a > m_amax) m_amax = a;
      m_asum += {16'd0, a};
      if (b < m_bmin) m_bmin = b;
      if (b > m_bmax) m_bmax = b;
      m_bsum += {16'd0, b};
    end
  endtask

  // Queue the first n bytes of the frame the model currently describes.
  task automatic push_frame(input int n);
    logic [239:0] v;
    logic [7:0]   b, chk;
    v   = {m_bsum, m_bmax, m_bmin, m_asum, m_amax, m_amin, m_cnt};
    chk = '0;
    for (int i = 0; i < 30; i++) begin
      b = v[i*8 +: 8];
      chk ^= b;
      if (i < n) exp_q.push_back(b);
    end
    if (n == 31) exp_q.push_back(chk);
  endtask

  task automatic do_sample(input logic [31:0] a, input logic [31:0] b);
    sample_valid = 1'b1; int_ack_lat = a; spi_lat = b;
    tick();
    sample_valid = 1'b0;
    model_sample(a, b);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
  endtask

  task automatic start_read(input int n_push);
    push_frame(n_push);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic read_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      rd_next = 1'b1;
      tick();
      rd_next = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; int_ack_lat = '0; spi_lat = '0;
    clear = 1'b0; rd_start = 1'b0; rd_next = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b0;

    // Reset state and empty frame: FF bytes in the two min fields, checksum 00
    check("rst_sample_cnt", {48'd0, sample_cnt}, 64'd0);
    check("rst_rd_active", {63'd0, rd_active}, 64'd0);
    check("rst_rd_byte", {56'd0, rd_byte}, 64'd0);
    check("rst_saturated", {63'd0, saturated}, 64'd0);
    start_read(31);
    check("start_rd_active", {63'd0, rd_active}, 64'd1);
    read_bytes(31);
    check("end_rd_active", {63'd0, rd_active}, 64'd0);
    check("end_rd_byte", {56'd0, rd_byte}, 64'd0);

    // Three samples: A 40/250/390, B 3/9/19
    do_sample(32'd100, 32'd7);
    do_sample(32'd40, 32'd9);
    do_sample(32'd250, 32'd3);
    check("cnt_after_3", {48'd0, sample_cnt}, 64'd3);
    start_read(31);
    read_bytes(31);

    // rd_start coincident with a sample: frame holds count=2, live count=3
    do_clear();
    do_sample(32'd10, 32'd20);
    do_sample(32'd30, 32'd15);
    push_frame(31);
    rd_start = 1'b1; sample_valid = 1'b1; int_ack_lat = 32'd5; spi_lat = 32'd5;
    tick();
    rd_start = 1'b0; sample_valid = 1'b0;
    model_sample(32'd5, 32'd5);
    check("cnt_after_start_sample", {48'd0, sample_cnt}, 64'd3);
    read_bytes(6);
    // Sample and an ignored rd_start mid-frame must not disturb the bytes in flight
    sample_valid = 1'b1; int_ack_lat = 32'd1; spi_lat = 32'd1000; rd_start = 1'b1;
    tick();
    sample_valid = 1'b0; rd_start = 1'b0;
    model_sample(32'd1, 32'd1000);
    read_bytes(25);
    check("cnt_after_inject", {48'd0, sample_cnt}, 64'd4);
    check("inject_rd_active", {63'd0, rd_active}, 64'd0);

    // clear with sample_valid: sample dropped
    clear = 1'b1; sample_valid = 1'b1; int_ack_lat = 32'd77; spi_lat = 32'd77;
    tick();
    clear = 1'b0; sample_valid = 1'b0;
    model_reset();
    check("clear_wins_cnt", {48'd0, sample_cnt}, 64'd0);
    do_sample(32'hFFFF_FFFF, 32'd1);
    start_read(31);
    read_bytes(31);

    // Saturation: count forced to FFFE, three samples, only one accepted
    do_clear();
    force dut.count_q = 16'hFFFE;
    #2;
    release dut.count_q;
    m_cnt = 16'hFFFE;
    check("sat_before", {63'd0, saturated}, 64'd0);
    do_sample(32'd10, 32'd20);
    do_sample(32'd11, 32'd21);
    do_sample(32'd12, 32'd22);
    check("sat_cnt", {48'd0, sample_cnt}, 64'hFFFF);
    check("sat_flag", {63'd0, saturated}, 64'd1);
    start_read(31);
    read_bytes(31);
    do_clear();
    check("sat_cleared", {63'd0, saturated}, 64'd0);
    check("sat_cnt_cleared", {48'd0, sample_cnt}, 64'd0);

    // Reset at byte index 12 aborts the frame; next frame restarts cleanly
    do_sample(32'd7, 32'd8);
    start_read(12);
    read_bytes(12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("abort_rd_active", {63'd0, rd_active}, 64'd0);
    check("abort_rd_byte", {56'd0, rd_byte}, 64'd0);
    check("abort_cnt", {48'd0, sample_cnt}, 64'd0);
    do_sample(32'd3, 32'd4);
    start_read(31);
    read_bytes(31);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
